// File: rtl/uart_ram_dump.sv
// uart_ram_dump: streams RAM words to the UART byte handshake, LSB first.
// Define DUMP_CHECKSUM_EN to append a mod-256 sum byte after the data.
module uart_ram_dump #(
  parameter int XLEN     = 32,
  parameter int ADDR_LEN = 14
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] start_addr,
  input  logic [ADDR_LEN:0]   word_cnt,
  output logic                busy,
  output logic                done,
  input  logic                ram_gnt,
  output logic                ram_en,
  output logic [ADDR_LEN-1:0] ram_addr,
  input  logic [XLEN-1:0]     ram_rd_data,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready
);
`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, CSUM} state_t;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND} state_t;
`endif
  state_t              state_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [ADDR_LEN:0]   rem_q;
  logic [XLEN-1:0]     sh_q;
  logic [1:0]          idx_q;
  logic                done_q;
  logic                xfer;
  assign xfer     = tx_valid && tx_ready;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign ram_en   = (state_q == RD) && ram_gnt;
  assign ram_addr = addr_q;
`ifdef DUMP_CHECKSUM_EN
  assign tx_valid = (state_q == SEND) || (state_q == CSUM);
  assign tx_data  = (state_q == CSUM) ? csum_q : sh_q[7:0];
`else
  assign tx_valid = state_q == SEND;
  assign tx_data  = sh_q[7:0];
`endif
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q <= start_addr;
          rem_q  <= word_cnt;
`ifdef DUMP_CHECKSUM_EN
          csum_q <= '0;
          state_q <= (word_cnt == '0) ? CSUM : RD;
`else
          if (word_cnt == '0) done_q <= 1'b1;
          else state_q <= RD;
`endif
        end
        RD: if (ram_gnt) state_q <= WAIT;
        WAIT: begin
          sh_q    <= ram_rd_data;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: if (xfer) begin
          sh_q  <= sh_q >> 8;
          idx_q <= idx_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
          csum_q <= csum_q + sh_q[7:0];
`endif
          if (idx_q == 2'd3) begin
            addr_q <= addr_q + ADDR_LEN'(1);
            rem_q  <= rem_q - (ADDR_LEN+1)'(1);
            if (rem_q == (ADDR_LEN+1)'(1)) begin
`ifdef DUMP_CHECKSUM_EN
              state_q <= CSUM;
`else
              done_q  <= 1'b1;
              state_q <= IDLE;
`endif
            end else begin
              state_q <= RD;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: if (xfer) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ram_dump.sv
// tb_uart_ram_dump: scoreboard bench for uart_ram_dump (RAM model, byte/address queues).
module tb_uart_ram_dump;
  logic        clk = 1'b0, rstb = 1'b0, start = 1'b0, ram_gnt = 1'b1, tx_ready = 1'b1;
  logic [13:0] start_addr = '0;
  logic [14:0] word_cnt = '0;
  logic        busy, done, ram_en, tx_valid;
  logic [13:0] ram_addr;
  logic [31:0] ram_rd_data = '0;
  logic [7:0]  tx_data;
  int tests = 0, fails = 0, nbytes = 0, ndone = 0;
  logic [7:0]  q[$];
  logic [13:0] aq[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = '0;

  uart_ram_dump dut (
    .clk(clk), .rstb(rstb), .start(start), .start_addr(start_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .ram_gnt(ram_gnt), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [13:0] a);
    return (a == 14'h10) ? 32'h44332211 : ({18'h2A5A5, a} ^ {a, 18'h01234});
  endfunction

  always @(posedge clk) if (ram_en) ram_rd_data <= mem_f(ram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done) ndone++;

  always @(negedge clk) begin
    if (rstb) begin
      if (ram_en) begin
        chk("addr_expected", 32'(aq.size() != 0), 32'd1);
        if (aq.size() != 0) chk("ram_addr", 32'(ram_addr), 32'(aq.pop_front()));
      end
      if (pv && !pr) begin
        chk("valid_hold", 32'(tx_valid), 32'd1);
        chk("data_hold", 32'(tx_data), 32'(pd));
      end
      if (tx_valid && tx_ready) begin
        chk("byte_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q.pop_front()));
        nbytes++;
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_dump(input logic [13:0] a, input logic [14:0] n);
    logic [7:0] sum = '0;
    logic [31:0] w;
    for (int i = 0; i < int'(n); i++) begin
      aq.push_back(a + 14'(i));
      w = mem_f(a + 14'(i));
      for (int b = 0; b < 4; b++) begin
        q.push_back(w[8*b +: 8]);
        sum += w[8*b +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    q.push_back(sum);
`endif
    start = 1'b1; start_addr = a; word_cnt = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = done;
      tick();
    end
    tx_ready = 1'b1;
    chk("done_seen", 32'(got), 32'd1);
    chk("bytes_left", 32'(q.size()), 32'd0);
    chk("addrs_left", 32'(aq.size()), 32'd0);
  endtask

  initial begin
    int last, base, nd;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    tick();
    rstb = 1'b1;
    tick();
    // exact cycle timing of a one-word dump
`ifdef DUMP_CHECKSUM_EN
    last = 8;
`else
    last = 7;
`endif
    start_dump(14'h10, 15'd1);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      chk($sformatf("lat_ram_en_c%0d", c), 32'(ram_en), 32'(c == 1));
      chk($sformatf("lat_valid_c%0d", c), 32'(tx_valid), 32'(c >= 3 && c < last));
      chk($sformatf("lat_done_c%0d", c), 32'(done), 32'(c == last));
      chk($sformatf("lat_busy_c%0d", c), 32'(busy), 32'(c < last));
      tick();
    end
    chk("t1_bytes_left", 32'(q.size()), 32'd0);
    tick();
    start_dump(14'h3FFE, 15'd3);
    wait_done(1'b0, 200);
    tick();
    start_dump(14'h0123, 15'd5);
    wait_done(1'b1, 1000);
    ram_gnt = 1'b0;
    start_dump(14'h0100, 15'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_ram_en", 32'(ram_en), 32'd0);
      chk("stall_valid", 32'(tx_valid), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    ram_gnt = 1'b1;
    wait_done(1'b0, 200);
    start_dump(14'h0, 15'd0);
`ifdef DUMP_CHECKSUM_EN
    wait_done(1'b0, 50);
`else
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_valid", 32'(tx_valid), 32'd0);
    tick();
`endif
    tick();
    base = nbytes;
    start_dump(14'h0200, 15'd2);
    for (int i = 0; i < 100 && nbytes != base + 6; i++) tick();
    chk("rst_reach_byte2", 32'(nbytes - base), 32'd6);
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    nd = ndone;
    rstb = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_tx_data", 32'(tx_data), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    q.delete(); aq.delete();
    tick(); tick(); tick();
    rstb = 1'b1;
    tick(); tick();
    chk("abort_no_done", 32'(ndone), 32'(nd));
    start_dump(14'h0040, 15'd2);
    wait_done(1'b1, 500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_ram_dump.md
# uart_ram_dump

Readback engine that streams a region of the core RAM out over the UART transmit path, one byte at a time, least-significant byte first. It is the counterpart of the UART software-upgrade loader: the loader writes RAM from UART bytes, and this block reads RAM words back to UART bytes so the host can verify an image. It sits beside `uart_mgr` in `soc`. It shares the RAM port A through an external grant, and it drives the same byte-wide transmit handshake that the core uses for UART output.

## Interface
Parameters:
- `XLEN`, 32, RAM word width; fixed at 32 (4 bytes per word).
- `ADDR_LEN`, 14, RAM word-address width.

Ports:
- `clk` input 1: single clock.
- `rstb` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle request to begin a dump; sampled only in IDLE.
- `start_addr` input ADDR_LEN: first word address; sampled with `start`.
- `word_cnt` input ADDR_LEN+1: number of words to send; sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse when the dump completes.
- `ram_gnt` input 1: RAM port available to this block in this cycle.
- `ram_en` output 1: RAM read strobe.
- `ram_addr` output ADDR_LEN: RAM word address.
- `ram_rd_data` input XLEN: RAM read data, valid one cycle after `ram_en`.
- `tx_valid` output 1: byte available.
- `tx_data` output 8: byte to transmit.
- `tx_ready` input 1: UART can accept a byte.

## Operation
- The FSM has five states: IDLE, RD, WAIT, SEND, CSUM.
- **IDLE**
  - On `start`, latch `start_addr` into the address counter and `word_cnt` into the remaining-word counter, and clear the checksum.
  - If `word_cnt` is 0, go to CSUM when the checksum is compiled in, otherwise go straight to IDLE with `done` asserted.
  - If `word_cnt` is nonzero, go to RD.
- **RD**
  - `ram_en` = `ram_gnt`; `ram_addr` = the address counter.
  - Stay in RD while `ram_gnt` is 0. When `ram_gnt` is 1, go to WAIT.
- **WAIT**
  - Capture `ram_rd_data` into a 32-bit shift register, set the byte index to 0, and go to SEND.
- **SEND**
  - `tx_valid` = 1 and `tx_data` = the shift register's low byte.
  - A byte transfers in a cycle where `tx_valid` and `tx_ready` are both 1. On each transfer, shift the register right by 8, increment the byte index, and add the byte to the checksum.
  - After the 4th transfer:
    - increment the address modulo 2^ADDR_LEN and decrement the remaining-word count;
    - if remaining is now 0, go to CSUM when enabled, else assert `done` and go to IDLE;
    - otherwise go to RD.
- **CSUM** (only with the macro): `tx_valid` = 1 and `tx_data` = the checksum. On transfer, assert `done` and go to IDLE.
- Handshake rules:
  - Once `tx_valid` is high, `tx_valid` and `tx_data` stay stable until the transfer.
  - `ram_en` is never asserted outside RD.
- `start` is ignored when not in IDLE.
- Address wrap: the address after 2^ADDR_LEN−1 is 0.

## Timing
- Reset values:
  - `busy`, `done`, `ram_en`, `tx_valid` = 0;
  - `ram_addr`, `tx_data` = 0;
  - FSM in IDLE; all counters and the checksum = 0.
- Reset asserted mid-dump aborts immediately: outputs go to reset values and no `done` is issued.
- Latency with `ram_gnt` = 1 and `tx_ready` = 1:
  - `start` in cycle 0, `ram_en` in cycle 1, capture in cycle 2, first `tx_valid` in cycle 3.
  - Bytes 0–3 go out in cycles 3–6; the next `ram_en` is in cycle 7.
  - Steady state is 6 cycles per word.
- `done` is a registered pulse in the cycle after the final transfer; `busy` falls in that same cycle.
- `ram_gnt` low in RD stalls the block indefinitely without side effects.
- `tx_ready` low in SEND stalls it with the byte held.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - one trailer byte is sent after the data, equal to the sum of all data bytes modulo 256;
  - with `word_cnt` = 0, the dump is the single byte 0x00.
- `DUMP_CHECKSUM_EN` undefined:
  - no CSUM state and no trailer;
  - with `word_cnt` = 0, `done` pulses the cycle after `start` and no bytes are sent.

## Test plan
- RAM[0x10] = 0x44332211, `start_addr` = 0x10, `word_cnt` = 1, `tx_ready` = 1 → bytes 0x11, 0x22, 0x33, 0x44 in cycles 3–6, then `done` in cycle 7; with the macro, 0xAA precedes `done`.
- `word_cnt` = 3 at `start_addr` = 2^ADDR_LEN−2 → reads at addresses 0x3FFE, 0x3FFF, 0x0000 (wrap), 12 bytes in order.
- `tx_ready` toggled randomly → every byte appears exactly once, `tx_data` stays stable while `tx_valid` is high and unaccepted, and the byte order is unchanged.
- `ram_gnt` held low for 20 cycles in RD → `ram_en` = 0 throughout, no `tx_valid`; resumes normally when the grant returns.
- `word_cnt` = 0 → without the macro, `done` in cycle 1 and zero bytes; with it, a single byte 0x00 then `done`.
- `rstb` pulsed low during byte 2 of word 1 → all outputs go to zero at once, no `done`; a subsequent `start` dumps correctly from its new `start_addr`.
